// File: rtl/neuron_mac.sv
// neuron_mac: Q8.24 dot product of N_IN x/w pairs plus bias, saturated, for a downstream tanh stage
module neuron_mac #(
  parameter int WIDTH = 32,
  parameter int FL = 24,
  parameter int N_IN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] bias,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);
  typedef enum logic [1:0] {ACCUM, DRAIN, BIAS, DONE} state_t;
  localparam int CW = $clog2(N_IN);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] prod_reg, prod_sat, sum_sat;
  logic p_vld, accept, last;
  logic signed [WIDTH+7:0] acc;
  logic signed [2*WIDTH-1:0] prod_full, prod_sh;
  logic signed [WIDTH+8:0] sum;
  logic [WIDTH:0] prod_hi;
  logic [9:0] sum_hi;
  assign in_ready = en && (state == ACCUM);
  assign accept = en && in_valid && in_ready;
  assign last = count == CW'(N_IN - 1);
  assign prod_full = $signed(x) * $signed(w);
  assign prod_sh = prod_full >>> FL;
  // value fits in WIDTH bits only when everything above the sign bit is a sign copy
  assign prod_hi = prod_sh[2*WIDTH-1:WIDTH-1];
  assign prod_sat = (prod_hi == '0 || prod_hi == '1) ? prod_sh[WIDTH-1:0] : (prod_sh[2*WIDTH-1] ? MIN : MAX);
  assign sum = {acc[WIDTH+7], acc} + {{9{bias[WIDTH-1]}}, bias};
  assign sum_hi = sum[WIDTH+8:WIDTH-1];
  assign sum_sat = (sum_hi == '0 || sum_hi == '1) ? sum[WIDTH-1:0] : (sum[WIDTH+8] ? MIN : MAX);
  always_comb begin
    state_n = state;
    state_n = state == ACCUM ? ((accept && last) ? DRAIN : ACCUM) :
              state == DRAIN ? BIAS :
              state == BIAS  ? DONE : ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      count <= '0;
      prod_reg <= '0;
      p_vld <= 1'b0;
      acc <= '0;
      y <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      state <= state_n;
      count <= accept ? (last ? '0 : count + 1'b1) : count;
      prod_reg <= accept ? prod_sat : prod_reg;
      p_vld <= accept;
      acc <= state == DONE ? '0 : p_vld ? acc + {{8{prod_reg[WIDTH-1]}}, prod_reg} : acc;
      y <= state == BIAS ? sum_sat : y;
      out_valid <= state == DONE;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vectors with a y scoreboard and pulse-latency checks
module tb_neuron_mac;
  logic clk = 0, rst = 1, en = 1, in_valid = 0;
  logic [31:0] x = 0, w = 0, bias = 0;
  logic in_ready, out_valid;
  logic [31:0] y;
  logic [31:0] xv[4], wv[4];
  logic [31:0] sb[$];
  logic ov_q = 0;
  int passed = 0, total = 0;

  neuron_mac dut (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
                  .x(x), .w(w), .bias(bias), .out_valid(out_valid), .y(y));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // score y on the first cycle of each out_valid pulse
  always @(negedge clk) begin
    if (out_valid && !ov_q) begin
      if (sb.size() == 0) begin
        total++;
        $error("FAIL y_unexpected: got pulse with y=%h expected none", y);
      end else chk("y", y, sb.pop_front());
    end
    ov_q = out_valid;
  end

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    x = a; w = b; in_valid = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
  endtask

  task automatic run_vec(input logic [31:0] b, input logic [31:0] e, input bit hold);
    bias = b;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) send_pair(xv[i], wv[i]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = hold;
        x = 32'h7F000000;
        w = 32'h7F000000;
      end
      chk("ov_early", out_valid, 0);
      chk("ready_busy", in_ready, 0);
    end
    @(negedge clk);
    chk("ov_pulse", out_valid, 1);
    in_valid = 0;
    chk("ready_back", in_ready, 1);
    @(negedge clk);
    chk("ov_single", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_y", y, 0);
    rst = 0;
    #1 chk("rst_ready", in_ready, 1);
    // basic
    xv = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
    wv = '{32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000};
    run_vec(32'h00400000, 32'h02400000, 0);
    // negative
    xv = '{32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000};
    run_vec(32'h0, 32'hFE000000, 0);
    // floor truncation
    xv = '{32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0};
    wv = '{32'h00000001, 32'h00000001, 32'h0, 32'h0};
    run_vec(32'h0, 32'hFFFFFFFF, 0);
    // positive and negative saturation
    xv = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000};
    wv = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000};
    run_vec(32'h7F000000, 32'h7FFFFFFF, 0);
    xv = '{32'h81000000, 32'h81000000, 32'h81000000, 32'h81000000};
    run_vec(32'h0, 32'h80000000, 0);
    // stall between accepts 2 and 3 and during BIAS
    bias = 32'h00400000;
    sb.push_back(32'h02400000);
    send_pair(32'h01000000, 32'h00800000);
    send_pair(32'h01000000, 32'h00800000);
    @(negedge clk);
    en = 0; in_valid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
    end
    en = 1;
    send_pair(32'h01000000, 32'h00800000);
    send_pair(32'h01000000, 32'h00800000);
    @(negedge clk);
    in_valid = 0;
    chk("stall_ov_drain", out_valid, 0);
    @(negedge clk);
    en = 0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ov_bias", out_valid, 0);
      chk("stall_ready2", in_ready, 0);
      chk("stall_y_hold", y, 32'h80000000);
    end
    en = 1;
    @(negedge clk);
    chk("stall_ov_done", out_valid, 0);
    @(negedge clk);
    chk("stall_ov_pulse", out_valid, 1);
    @(negedge clk);
    chk("stall_ov_single", out_valid, 0);
    // reset mid-vector discards partial sum
    send_pair(32'h7F000000, 32'h7F000000);
    send_pair(32'h7F000000, 32'h7F000000);
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_ov", out_valid, 0);
    rst = 0;
    #1 chk("mid_rst_ready", in_ready, 1);
    xv = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
    wv = '{32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000};
    run_vec(32'h00400000, 32'h02400000, 1);
    // the held pair must not have leaked into this vector
    run_vec(32'h00400000, 32'h02400000, 0);
    repeat (10) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
